// File: rtl/sync_fifo_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_gen2
//  Description : Single-clock FIFO built from inferred storage. Offers a
//                registered (standard) read mode or first-word-fall-through
//                mode. Provides programmable almost-full/almost-empty flags,
//                an occupancy count and write-ack/overflow/underflow pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_gen2 #(
    parameter int    WIDTH     = 64,
    parameter int    ADDR_W    = 8,
    parameter string READ_MODE = "std",
    parameter int    AF_THRESH = (2**ADDR_W) - 1,
    parameter int    AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  din,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  dout,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   data_count,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH_CNT = c_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AF        = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AE        = AE_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] c_PTR_ONE = 1;
    // Flag values for an empty FIFO, loaded at reset.
    localparam logic            c_AF_RST    = (c_AF == '0);

    // Elaboration-time sanity checks on the configuration.
    if ((READ_MODE != "std") && (READ_MODE != "fwft")) begin : g_bad_mode
        $error("sync_fifo_gen2: READ_MODE must be \"std\" or \"fwft\"");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > c_DEPTH)) begin : g_bad_af
        $error("sync_fifo_gen2: AF_THRESH out of range 1..2**ADDR_W");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > c_DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_gen2: AE_THRESH out of range 0..2**ADDR_W-1");
    end

    logic [WIDTH-1:0]  r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_wr_ack;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_count_nxt;

    // Acceptance is decided from the registered flags of the current cycle.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    // Occupancy after this edge; a matched read+write leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write port; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, count, status flags and handshake pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= c_AF_RST;
            r_almost_empty <= 1'b1;
            r_wr_ack       <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_DEPTH_CNT);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_AF);
            r_almost_empty <= (w_count_nxt <= c_AE);
            r_wr_ack       <= w_wr_acc;
            r_overflow     <= wr_en & r_full;
            r_underflow    <= rd_en & r_empty;
        end
    end

    if (READ_MODE == "fwft") begin : g_fwft
        // Head word is presented combinationally whenever the FIFO holds data.
        assign dout       = r_empty ? '0 : r_mem[r_rd_ptr];
        assign data_valid = ~r_empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_dout;
        logic             r_data_valid;

        // Registered read: dout updates only on an accepted read, else holds.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dout       <= '0;
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
        end

        assign dout       = r_dout;
        assign data_valid = r_data_valid;
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign data_count   = r_count;
    assign wr_ack       = r_wr_ack;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_gen2
//  Description : Self-checking bench for sync_fifo_gen2. A std-mode and a
//                fwft-mode instance share one stimulus stream; a queue model
//                predicts flags/pulses and the read data order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_gen2;

    localparam int c_W  = 16;
    localparam int c_AW = 3;
    localparam int c_N  = 2**c_AW;
    localparam int c_AF = c_N - 1;
    localparam int c_AE = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic [c_W-1:0]  din = '0;

    logic [c_W-1:0]  s_dout, f_dout;
    logic            s_dv, f_dv, s_full, f_full, s_empty, f_empty;
    logic            s_af, f_af, s_ae, f_ae, s_ack, f_ack;
    logic            s_ovf, f_ovf, s_unf, f_unf;
    logic [c_AW:0]   s_cnt, f_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    // Reference model: FIFO contents plus the pulses expected after the edge.
    logic [c_W-1:0] m_q[$];
    logic [c_W-1:0] exp_std[$];
    logic [c_W-1:0] exp_fw[$];
    logic           e_ack = 0, e_ovf = 0, e_unf = 0, e_dv = 0;
    logic [c_W-1:0] e_last = '0;

    always #5 clk = ~clk;

    sync_fifo_gen2 #(.WIDTH(c_W), .ADDR_W(c_AW), .READ_MODE("std"),
                     .AF_THRESH(c_AF), .AE_THRESH(c_AE)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .data_count(s_cnt),
        .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_gen2 #(.WIDTH(c_W), .ADDR_W(c_AW), .READ_MODE("fwft"),
                     .AF_THRESH(c_AF), .AE_THRESH(c_AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt),
        .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every status output of both instances against the model.
    task automatic check_state();
        int sz;
        sz = m_q.size();
        chk("s_count", 32'(s_cnt), sz);
        chk("f_count", 32'(f_cnt), sz);
        chk("s_full", 32'(s_full), 32'(sz == c_N));
        chk("f_full", 32'(f_full), 32'(sz == c_N));
        chk("s_empty", 32'(s_empty), 32'(sz == 0));
        chk("f_empty", 32'(f_empty), 32'(sz == 0));
        chk("s_afull", 32'(s_af), 32'(sz >= c_AF));
        chk("f_afull", 32'(f_af), 32'(sz >= c_AF));
        chk("s_aempty", 32'(s_ae), 32'(sz <= c_AE));
        chk("f_aempty", 32'(f_ae), 32'(sz <= c_AE));
        chk("s_wr_ack", 32'(s_ack), 32'(e_ack));
        chk("f_wr_ack", 32'(f_ack), 32'(e_ack));
        chk("s_overflow", 32'(s_ovf), 32'(e_ovf));
        chk("f_overflow", 32'(f_ovf), 32'(e_ovf));
        chk("s_underflow", 32'(s_unf), 32'(e_unf));
        chk("f_underflow", 32'(f_unf), 32'(e_unf));
        chk("s_data_valid", 32'(s_dv), 32'(e_dv));
        chk("f_data_valid", 32'(f_dv), 32'(sz != 0));
        if (!s_dv) chk("s_dout_hold", 32'(s_dout), 32'(e_last));
    endtask

    // One clock cycle: check current state, apply inputs, advance the model.
    task automatic cycle(input logic rn, input logic we, input logic [c_W-1:0] d, input logic re);
        logic wacc, racc;
        logic [c_W-1:0] h;
        @(negedge clk);
        if (chk_en) check_state();
        rst_n = rn; wr_en = we; din = d; rd_en = re;
        if (!rn) begin
            m_q.delete();
            e_ack = 0; e_ovf = 0; e_unf = 0; e_dv = 0; e_last = '0;
        end else begin
            wacc = we && (m_q.size() < c_N);
            racc = re && (m_q.size() != 0);
            e_ack = wacc;
            e_ovf = we && !wacc;
            e_unf = re && !racc;
            e_dv  = racc;
            if (racc) begin
                h = m_q.pop_front();
                exp_std.push_back(h);
                exp_fw.push_back(h);
                e_last = h;
            end
            if (wacc) m_q.push_back(d);
        end
    endtask

    // std monitor: every valid dout is the next word in read order.
    always @(negedge clk) begin
        #1;
        if (chk_en && s_dv) begin
            if (exp_std.size() == 0) chk("s_unexpected_valid", 32'(s_dout), 32'hFFFF_FFFF);
            else chk("s_dout", 32'(s_dout), 32'(exp_std.pop_front()));
        end
    end

    // fwft monitor: the word being popped is the head on dout.
    always @(negedge clk) begin
        #1;
        if (chk_en && rst_n && f_dv && rd_en) begin
            if (exp_fw.size() == 0) chk("f_unexpected_pop", 32'(f_dout), 32'hFFFF_FFFF);
            else chk("f_dout", 32'(f_dout), 32'(exp_fw.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with write requests held active.
        cycle(1'b0, 1'b1, 16'h0001, 1'b0);
        chk_en = 1;
        cycle(1'b0, 1'b1, 16'h0002, 1'b1);
        cycle(1'b0, 1'b1, 16'h0003, 1'b0);
        @(negedge clk);
        chk("s_dout_reset", 32'(s_dout), 32'h0);
        chk("f_dout_reset", 32'(f_dout), 32'h0);

        // 2: fill with 0x11..0x18, then one rejected write.
        for (int i = 0; i < c_N; i++) cycle(1'b1, 1'b1, 16'(16'h11 + i), 1'b0);
        cycle(1'b1, 1'b1, 16'h0099, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);

        // 3: drain all words, one rejected read, then idle to see dout held.
        for (int i = 0; i < c_N; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);

        // 4: single word into empty FIFO, then pop it.
        cycle(1'b1, 1'b1, 16'h00A5, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);

        // 5: simultaneous read+write at full, at empty and at count 4.
        for (int i = 0; i < c_N; i++) cycle(1'b1, 1'b1, 16'(16'h20 + i), 1'b0);
        cycle(1'b1, 1'b1, 16'h00EE, 1'b1);
        for (int i = 0; i < c_N - 1; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b1, 16'h0033, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'(16'h40 + i), 1'b0);
        cycle(1'b1, 1'b1, 16'h0044, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);

        // 6: random traffic across pointer wrap, then reset mid-burst.
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        cycle(1'b0, 1'b1, 16'h0BAD, 1'b1);
        cycle(1'b1, 1'b1, 16'h005A, 1'b0);
        cycle(1'b1, 1'b1, 16'h005B, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b0);

        @(negedge clk);
        #2;
        chk("s_scoreboard_drained", 32'(exp_std.size()), 32'h0);
        chk("f_scoreboard_drained", 32'(exp_fw.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
